// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the pipeline (priority, misaligned loads split in two beats) and a debug/DMA port.
// Latency: aligned P and D accesses take 0 cycles (combinational); misaligned loads take 2; D read data is registered (1 cycle).
// Backpressure: P_Stall holds the pipeline; D waits for D_Gnt and is force-granted after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             P_Val,
    input  logic             P_Wr,
    input  logic [31:0]      P_Adr,
    input  logic [31:0]      P_WrDat,
    output logic [31:0]      P_RdDat,
    output logic             P_Stall,
    input  logic             D_Req,
    input  logic             D_Wr,
    input  logic [31:0]      D_Adr,
    input  logic [31:0]      D_WrDat,
    output logic             D_Gnt,
    output logic             D_RdVal,
    output logic [31:0]      D_RdDat,
    output logic             Mem_WrEn,
    output logic [31:0]      Mem_Adr,
    output logic [31:0]      Mem_WrDat,
    input  logic [31:0]      Mem_RdDat,
    output logic [CNT_W-1:0] ContCnt
);

    typedef enum logic {IDLE, P_HI} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] lo_buf;
    logic [1:0]  off;
    logic [31:0] base;
    logic [5:0]  sh;
    logic        force_d;
    logic        d_srv;
    logic        p_split;
    logic [3:0]  wait_inc;
    logic        unused_d_adr;

    assign off          = P_Adr[1:0];
    assign base         = {P_Adr[31:2], 2'b00};
    assign sh           = {1'b0, off, 3'b000};
    assign unused_d_adr = ^D_Adr[1:0];

    assign force_d  = (state == IDLE) && (wait_cnt == 4'(MAX_WAIT)) && D_Req;
    assign d_srv    = !reset && (state == IDLE) && D_Req && (force_d || !P_Val);
    assign p_split  = P_Val && !P_Wr && (off != 2'b00);
    assign wait_inc = (wait_cnt == 4'(MAX_WAIT)) ? wait_cnt : wait_cnt + 4'd1;

    assign D_Gnt     = d_srv;
    assign Mem_WrDat = d_srv ? D_WrDat : P_WrDat;
    assign Mem_WrEn  = d_srv ? D_Wr : (!reset && (state == IDLE) && P_Val && P_Wr);
    assign P_Stall   = !reset && (state == IDLE) && P_Val && (force_d || p_split);

    always_comb begin
        Mem_Adr = base;
        if (state == P_HI) begin
            Mem_Adr = base + 32'd4;
        end else if (d_srv) begin
            Mem_Adr = {D_Adr[31:2], 2'b00};
        end
    end

    // Big-endian merge; a shift of 32 (off == 0) yields zero, so no special case.
    assign P_RdDat = (state == P_HI) ? ((lo_buf << sh) | (Mem_RdDat >> (6'd32 - sh)))
                                     : Mem_RdDat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            lo_buf   <= 32'd0;
            D_RdVal  <= 1'b0;
            D_RdDat  <= 32'd0;
            ContCnt  <= '0;
        end else begin
            D_RdVal <= d_srv && !D_Wr;
            if (d_srv && !D_Wr) begin
                D_RdDat <= Mem_RdDat;
            end
            case (state)
                IDLE: begin
                    if (force_d) begin
                        wait_cnt <= 4'd0;
                        if (P_Val) begin
                            ContCnt <= ContCnt + 1'b1;
                        end
                    end else if (P_Val) begin
                        if (p_split) begin
                            lo_buf <= Mem_RdDat;
                            state  <= P_HI;
                        end
                        if (D_Req) begin
                            wait_cnt <= wait_inc;
                        end
                    end else if (D_Req) begin
                        wait_cnt <= 4'd0;
                    end
                end
                P_HI: begin
                    state <= IDLE;
                    if (D_Req) begin
                        wait_cnt <= wait_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
